// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared state type, constants and address check for the memory responder
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam logic [31:0] ERR_READ_VALUE = 32'h0;

  // Word-aligned and inside the array; compared at 33 bits so large depths cannot wrap.
  function automatic logic addr_ok(input logic [31:0] addr, input int depth_words);
    logic [32:0] limit;
    limit = 33'(depth_words) * 33'(BYTES_PER_WORD);
    return (addr[1:0] == 2'b00) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/byte_ram.sv
// rtl/byte_ram.sv - byte-organised storage with big-endian word write and combinational word read
module byte_ram
  import mem_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  localparam int NBYTES = DEPTH_WORDS * BYTES_PER_WORD;

  logic [7:0] r_mem [0:NBYTES-1];

  always_ff @(posedge clock) begin
    if (we) begin
      r_mem[{waddr, 2'd0}] <= wdata[31:24];
      r_mem[{waddr, 2'd1}] <= wdata[23:16];
      r_mem[{waddr, 2'd2}] <= wdata[15:8];
      r_mem[{waddr, 2'd3}] <= wdata[7:0];
    end
  end

  assign rdata = {r_mem[{raddr, 2'd0}], r_mem[{raddr, 2'd1}],
                  r_mem[{raddr, 2'd2}], r_mem[{raddr, 2'd3}]};

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - req/ready memory responder with wait states and alignment/range checking
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        ready,
  output logic        busy,
  output logic        addr_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  mem_state_t    r_state;
  mem_state_t    w_next;
  logic [CW-1:0] r_cnt;
  logic          r_wr;
  logic          r_err;
  logic [AW-1:0] r_widx;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;

  logic          w_accept;
  logic          w_ok;
  logic          w_direct;
  logic          w_access;
  logic          w_acc_wr;
  logic          w_we;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_wdata;
  logic [31:0]   w_ram_rdata;

  assign w_accept = (r_state == IDLE) && req;
  assign w_ok     = addr_ok(Address, DEPTH_WORDS);

  // With no wait states the access happens on the accepting edge, straight from the bus inputs.
  assign w_direct = w_accept && w_ok && (WAIT_CYCLES == 0);
  assign w_access = w_direct || ((r_state == WAIT) && (r_cnt == CW'(1)));
  assign w_acc_wr = w_direct ? wr : r_wr;
  assign w_we     = w_access && w_acc_wr;
  assign w_idx    = w_direct ? Address[AW+1:2] : r_widx;
  assign w_wdata  = w_direct ? WriteData : r_wdata;

  byte_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clock(clock),
    .we   (w_we),
    .waddr(w_idx),
    .wdata(w_wdata),
    .raddr(w_idx),
    .rdata(w_ram_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (req) begin
          w_next = (!w_ok || (WAIT_CYCLES == 0)) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == CW'(1)) begin
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ready    = (r_state == RESP);
    busy     = (r_state != IDLE);
    addr_err = (r_state == RESP) && r_err;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_widx  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_wr    <= wr;
        r_widx  <= Address[AW+1:2];
        r_wdata <= WriteData;
        r_err   <= !w_ok;
        r_cnt   <= w_ok ? CW'(WAIT_CYCLES) : '0;
        if (!w_ok) begin
          r_rdata <= ERR_READ_VALUE;
        end
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_access && !w_acc_wr) begin
        r_rdata <= w_ram_rdata;
      end
    end
  end

  assign ReadData = r_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder against a byte-level memory model
`timescale 1ns/1ps
module tb_mem_responder;

  localparam int DEPTH  = 64;
  localparam int NBYTES = DEPTH * 4;

  logic        clk;
  logic        rst;
  logic        req_v   [2];
  logic        wr_v    [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [31:0] rdata_v [2];
  logic        ready_v [2];
  logic        busy_v  [2];
  logic        err_v   [2];

  logic [7:0]  mb [2][NBYTES];
  logic [31:0] last_rd [2];
  int          n_vec;
  int          n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
    .clock(clk), .reset(rst), .req(req_v[0]), .wr(wr_v[0]), .Address(addr_v[0]),
    .WriteData(wdata_v[0]), .ReadData(rdata_v[0]), .ready(ready_v[0]), .busy(busy_v[0]),
    .addr_err(err_v[0])
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clock(clk), .reset(rst), .req(req_v[1]), .wr(wr_v[1]), .Address(addr_v[1]),
    .WriteData(wdata_v[1]), .ReadData(rdata_v[1]), .ready(ready_v[1]), .busy(busy_v[1]),
    .addr_err(err_v[1])
  );

  function automatic int wait_of(input int w);
    return (w == 0) ? 2 : 0;
  endfunction

  // Reference: byte array, big-endian word view, rejected accesses return zero.
  task automatic model_txn(input int w, input logic iswr, input logic [31:0] a, input logic [31:0] d,
                           output int e_edges, output logic e_err, output logic [31:0] e_rd);
    e_err = (a % 4 != 0) || (a >= NBYTES);
    if (e_err) begin
      e_edges    = 1;
      last_rd[w] = 32'h0;
    end else begin
      e_edges = wait_of(w) + 1;
      if (iswr) begin
        for (int k = 0; k < 4; k++) mb[w][a+k] = d[31-8*k -: 8];
      end else begin
        last_rd[w] = {mb[w][a], mb[w][a+1], mb[w][a+2], mb[w][a+3]};
      end
    end
    e_rd = last_rd[w];
  endtask

  // Drives one request, scrambles the bus while waiting, and reports what was seen at ready.
  task automatic do_txn(input int w, input logic iswr, input logic [31:0] a, input logic [31:0] d,
                        output int edges, output logic got_err, output logic [31:0] got_rd,
                        output logic got_busy);
    @(negedge clk);
    req_v[w] = 1'b1; wr_v[w] = iswr; addr_v[w] = a; wdata_v[w] = d;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    req_v[w] = 1'b0; addr_v[w] = $urandom; wdata_v[w] = $urandom; wr_v[w] = ~iswr;
    while (!ready_v[w] && edges < 16) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    got_err  = err_v[w];
    got_rd   = rdata_v[w];
    got_busy = busy_v[w];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int w = 0; w < 2; w++) begin
      req_v[w] = 1'b1; wr_v[w] = 1'b1; addr_v[w] = 32'h0; wdata_v[w] = 32'hFFFF_FFFF;
    end
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      n_vec++; if (ready_v[w] !== 1'b0) begin n_err++; $display("FAIL reset_ready[%0d] got=%b exp=0", w, ready_v[w]); end
      n_vec++; if (busy_v[w] !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d] got=%b exp=0", w, busy_v[w]); end
      n_vec++; if (err_v[w] !== 1'b0) begin n_err++; $display("FAIL reset_err[%0d] got=%b exp=0", w, err_v[w]); end
      n_vec++; if (rdata_v[w] !== 32'h0) begin n_err++; $display("FAIL reset_rdata[%0d] got=%h exp=0", w, rdata_v[w]); end
      req_v[w] = 1'b0;
      last_rd[w] = 32'h0;
    end
    rst = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      n_vec++; if (busy_v[w] !== 1'b0) begin n_err++; $display("FAIL post_reset_busy[%0d] got=%b exp=0", w, busy_v[w]); end
    end
  endtask

  task automatic test_fill();
    int e_ed, ed; logic e_er, er, bz; logic [31:0] e_rd, rd, v;
    for (int i = 0; i < DEPTH; i++) begin
      v = (32'(i) << 24) | ($urandom & 32'h00FF_FFFF);
      model_txn(0, 1'b1, 32'(4*i), v, e_ed, e_er, e_rd);
      do_txn(0, 1'b1, 32'(4*i), v, ed, er, rd, bz);
      n_vec++; if (ed !== e_ed || er !== e_er) begin n_err++; $display("FAIL fill[%0d] edges/err got=%0d/%b exp=%0d/%b", i, ed, er, e_ed, e_er); end
    end
  endtask

  task automatic test_write_read();
    int e_ed, ed; logic e_er, er, bz; logic [31:0] e_rd, rd;
    model_txn(0, 1'b1, 32'h10, 32'h1234_5678, e_ed, e_er, e_rd);
    do_txn(0, 1'b1, 32'h10, 32'h1234_5678, ed, er, rd, bz);
    n_vec++; if (ed !== 3) begin n_err++; $display("FAIL wr10_latency got=%0d exp=3", ed); end
    model_txn(0, 1'b0, 32'h10, 32'h0, e_ed, e_er, e_rd);
    do_txn(0, 1'b0, 32'h10, 32'h0, ed, er, rd, bz);
    n_vec++; if (ed !== 3) begin n_err++; $display("FAIL rd10_latency got=%0d exp=3", ed); end
    n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL rd10_err got=%b exp=0", er); end
    n_vec++; if (rd !== 32'h1234_5678) begin n_err++; $display("FAIL rd10_data got=%h exp=12345678", rd); end
    n_vec++; if (bz !== 1'b1) begin n_err++; $display("FAIL rd10_busy got=%b exp=1", bz); end
    n_vec++; if (dut.u_ram.r_mem[16] !== 8'h12) begin n_err++; $display("FAIL byte10 got=%h exp=12", dut.u_ram.r_mem[16]); end
    n_vec++; if (dut.u_ram.r_mem[19] !== 8'h78) begin n_err++; $display("FAIL byte13 got=%h exp=78", dut.u_ram.r_mem[19]); end
  endtask

  task automatic test_errors();
    int e_ed, ed; logic e_er, er, bz; logic [31:0] e_rd, rd;
    model_txn(0, 1'b0, 32'h11, 32'h0, e_ed, e_er, e_rd);
    do_txn(0, 1'b0, 32'h11, 32'h0, ed, er, rd, bz);
    n_vec++; if (ed !== 1 || er !== 1'b1) begin n_err++; $display("FAIL misalign edges/err got=%0d/%b exp=1/1", ed, er); end
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL misalign_data got=%h exp=0", rd); end
    model_txn(0, 1'b0, 32'hFC, 32'h0, e_ed, e_er, e_rd);
    do_txn(0, 1'b0, 32'hFC, 32'h0, ed, er, rd, bz);
    n_vec++; if (ed !== 3 || er !== 1'b0) begin n_err++; $display("FAIL lastword edges/err got=%0d/%b exp=3/0", ed, er); end
    n_vec++; if (rd !== e_rd) begin n_err++; $display("FAIL lastword_data got=%h exp=%h", rd, e_rd); end
    model_txn(0, 1'b0, 32'h100, 32'h0, e_ed, e_er, e_rd);
    do_txn(0, 1'b0, 32'h100, 32'h0, ed, er, rd, bz);
    n_vec++; if (ed !== 1 || er !== 1'b1) begin n_err++; $display("FAIL range edges/err got=%0d/%b exp=1/1", ed, er); end
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL range_data got=%h exp=0", rd); end
  endtask

  task automatic test_write_holds_rdata();
    int e_ed, ed; logic e_er, er, bz; logic [31:0] e_rd, rd;
    model_txn(0, 1'b0, 32'h10, 32'h0, e_ed, e_er, e_rd);
    do_txn(0, 1'b0, 32'h10, 32'h0, ed, er, rd, bz);
    n_vec++; if (rd !== 32'h1234_5678) begin n_err++; $display("FAIL hold_pre got=%h exp=12345678", rd); end
    model_txn(0, 1'b1, 32'h04, 32'h0, e_ed, e_er, e_rd);
    do_txn(0, 1'b1, 32'h04, 32'h0, ed, er, rd, bz);
    n_vec++; if (rd !== 32'h1234_5678) begin n_err++; $display("FAIL hold_write got=%h exp=12345678", rd); end
  endtask

  task automatic test_abort();
    int e_ed, ed; logic e_er, er, bz, seen; logic [31:0] e_rd, rd, prior;
    prior = {mb[0][32], mb[0][33], mb[0][34], mb[0][35]};
    seen = 1'b0;
    @(negedge clk);
    req_v[0] = 1'b1; wr_v[0] = 1'b1; addr_v[0] = 32'h20; wdata_v[0] = 32'hAAAA_5555;
    @(posedge clk);
    @(negedge clk);
    req_v[0] = 1'b0;
    seen |= ready_v[0];
    @(posedge clk);
    @(negedge clk);
    seen |= ready_v[0];
    rst = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); seen |= ready_v[0]; end
    rst = 1'b0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    repeat (4) begin @(posedge clk); @(negedge clk); seen |= ready_v[0]; end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_ready got=%b exp=0", seen); end
    model_txn(0, 1'b0, 32'h20, 32'h0, e_ed, e_er, e_rd);
    do_txn(0, 1'b0, 32'h20, 32'h0, ed, er, rd, bz);
    n_vec++; if (rd !== prior) begin n_err++; $display("FAIL abort_data got=%h exp=%h", rd, prior); end
    n_vec++; if (rd !== e_rd) begin n_err++; $display("FAIL abort_model got=%h exp=%h", rd, e_rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp0, exp4;
    int rdy_at[$];
    logic [31:0] rd_at[$];
    int busy_low;
    exp0 = {mb[0][0], mb[0][1], mb[0][2], mb[0][3]};
    exp4 = {mb[0][4], mb[0][5], mb[0][6], mb[0][7]};
    busy_low = 0;
    @(negedge clk);
    req_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = 32'h0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready_v[0]) begin rdy_at.push_back(k); rd_at.push_back(rdata_v[0]); end
      if (!busy_v[0] && rdy_at.size() == 1) busy_low++;
      if (k == 1) addr_v[0] = 32'h04;
      if (k == 5) addr_v[0] = 32'h0C;
      if (k == 7) req_v[0] = 1'b0;
    end
    last_rd[0] = exp4;
    n_vec++; if (rdy_at.size() !== 2) begin n_err++; $display("FAIL b2b_pulses got=%0d exp=2", rdy_at.size()); end
    n_vec++; if (busy_low !== 1) begin n_err++; $display("FAIL b2b_busy_low got=%0d exp=1", busy_low); end
    if (rdy_at.size() == 2) begin
      n_vec++; if (rdy_at[0] !== 3) begin n_err++; $display("FAIL b2b_first got=%0d exp=3", rdy_at[0]); end
      n_vec++; if (rdy_at[1] - rdy_at[0] !== 4) begin n_err++; $display("FAIL b2b_gap got=%0d exp=4", rdy_at[1] - rdy_at[0]); end
      n_vec++; if (rd_at[0] !== exp0) begin n_err++; $display("FAIL b2b_data0 got=%h exp=%h", rd_at[0], exp0); end
      n_vec++; if (rd_at[1] !== exp4) begin n_err++; $display("FAIL b2b_data4 got=%h exp=%h", rd_at[1], exp4); end
    end
  endtask

  task automatic test_wait0();
    int e_ed, ed; logic e_er, er, bz; logic [31:0] e_rd, rd;
    model_txn(1, 1'b1, 32'h08, 32'hCAFE_BABE, e_ed, e_er, e_rd);
    do_txn(1, 1'b1, 32'h08, 32'hCAFE_BABE, ed, er, rd, bz);
    n_vec++; if (ed !== 1) begin n_err++; $display("FAIL w0_wr_latency got=%0d exp=1", ed); end
    model_txn(1, 1'b0, 32'h08, 32'h0, e_ed, e_er, e_rd);
    do_txn(1, 1'b0, 32'h08, 32'h0, ed, er, rd, bz);
    n_vec++; if (ed !== 1 || er !== 1'b0) begin n_err++; $display("FAIL w0_rd edges/err got=%0d/%b exp=1/0", ed, er); end
    n_vec++; if (rd !== 32'hCAFE_BABE) begin n_err++; $display("FAIL w0_rd_data got=%h exp=cafebabe", rd); end
    model_txn(1, 1'b1, 32'h0A, 32'h1111_1111, e_ed, e_er, e_rd);
    do_txn(1, 1'b1, 32'h0A, 32'h1111_1111, ed, er, rd, bz);
    n_vec++; if (ed !== 1 || er !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL w0_misalign got=%0d/%b/%h exp=1/1/0", ed, er, rd); end
    model_txn(1, 1'b0, 32'h08, 32'h0, e_ed, e_er, e_rd);
    do_txn(1, 1'b0, 32'h08, 32'h0, ed, er, rd, bz);
    n_vec++; if (rd !== e_rd) begin n_err++; $display("FAIL w0_no_write got=%h exp=%h", rd, e_rd); end
  endtask

  task automatic test_random();
    int e_ed, ed, sel; logic e_er, er, bz, iswr; logic [31:0] e_rd, rd, a, d;
    for (int i = 0; i < 60; i++) begin
      sel  = $urandom_range(0, 9);
      iswr = 1'($urandom_range(0, 1));
      d    = $urandom;
      if (sel < 7)       a = 32'(4 * $urandom_range(0, DEPTH-1));
      else if (sel == 7) a = 32'(4 * $urandom_range(0, DEPTH-1) + $urandom_range(1, 3));
      else if (sel == 8) a = 32'(NBYTES + 4 * $urandom_range(0, DEPTH-1));
      else               a = $urandom | 32'h0000_0100;
      model_txn(0, iswr, a, d, e_ed, e_er, e_rd);
      do_txn(0, iswr, a, d, ed, er, rd, bz);
      n_vec++; if (ed !== e_ed) begin n_err++; $display("FAIL rnd[%0d] edges a=%h got=%0d exp=%0d", i, a, ed, e_ed); end
      n_vec++; if (er !== e_er) begin n_err++; $display("FAIL rnd[%0d] err a=%h got=%b exp=%b", i, a, er, e_er); end
      n_vec++; if (rd !== e_rd) begin n_err++; $display("FAIL rnd[%0d] data a=%h got=%h exp=%h", i, a, rd, e_rd); end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    for (int w = 0; w < 2; w++) begin
      req_v[w] = 1'b0; wr_v[w] = 1'b0; addr_v[w] = 32'h0; wdata_v[w] = 32'h0;
      last_rd[w] = 32'h0;
    end
    test_reset();
    test_fill();
    test_write_read();
    test_errors();
    test_write_holds_rdata();
    test_abort();
    test_back_to_back();
    test_wait0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
